// File: rtl/regf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regf_wb_arbiter
//
// Write-port controller for the pipeline register file.
//  * Arbitrates among NUM_REQ writeback sources for the single register-file
//    write port and registers the winner onto regf_we / rd_s / rd_v.
//  * Keeps a 32-entry busy scoreboard: dispatch sets a bit, a committed
//    writeback clears it. Issue logic uses it for RAW hazard checks.
//
// Configuration macro:
//   REGF_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest valid index wins
//                           undefined -> round-robin starting at an internal
//                                        pointer (default build)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid [NUM_REQ]      requester i has a writeback pending
//   req_rd    [NUM_REQ*5]    destination of requester i at [5i+4:5i]
//   req_data  [NUM_REQ*32]   value of requester i at [32i+31:32i]
//   req_ready [NUM_REQ]      one-hot grant (combinational from req_valid)
//   disp_valid, disp_rd      dispatch allocates destination disp_rd
//   regf_we, rd_s, rd_v      registered register-file write port
//   busy [32]                scoreboard, bit r = write to xr outstanding
//
// Handshake: a transfer happens on a rising edge where
// req_valid[i] && req_ready[i]. req_ready depends combinationally on
// req_valid; a requester must never derive req_valid from req_ready, and
// once valid it holds valid/rd/data stable until its transfer. The grant is
// forced low while rst is high, so nothing transfers during reset.
// ---------------------------------------------------------------------------
module regf_wb_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*5-1:0]  req_rd,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  disp_valid,
  input  logic [4:0]            disp_rd,
  output logic                  regf_we,
  output logic [4:0]            rd_s,
  output logic [31:0]           rd_v,
  output logic [31:0]           busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

  // -------------------------------------------------------------------------
  // Search start pointer
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] w_ptr;
  logic             w_found;
  logic [IDX_W-1:0] w_gidx;
  logic             w_xfer;

`ifdef REGF_ARB_FIXED_PRIO_EN
  // Fixed priority: the search always starts at requester 0.
  assign w_ptr = '0;
`else
  logic [IDX_W-1:0] r_ptr;

  // After a grant to g the search resumes at g+1, so every requester that
  // stays valid is served within NUM_REQ cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= (w_gidx == LAST_IDX) ? '0 : w_gidx + 1'b1;
    end
  end

  assign w_ptr = r_ptr;
`endif

  // -------------------------------------------------------------------------
  // Winner search: first valid requester at or after w_ptr, wrapping.
  // -------------------------------------------------------------------------
  always_comb begin
    logic [IDX_W:0] idx;
    idx     = '0;
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, w_ptr} + (IDX_W + 1)'(k);
      if (idx >= NUM_REQ_W) begin
        idx = idx - NUM_REQ_W;
      end
      if (!w_found && req_valid[idx[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = idx[IDX_W-1:0];
      end
    end
  end

  // A grant issued during reset would be lost, so suppress it entirely.
  assign w_xfer = w_found && !rst;

  // -------------------------------------------------------------------------
  // One-hot grant and selected payload
  // -------------------------------------------------------------------------
  logic [NUM_REQ-1:0] w_grant;
  logic [4:0]         w_sel_rd;
  logic [31:0]        w_sel_data;

  always_comb begin
    w_grant    = '0;
    w_sel_rd   = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gidx == IDX_W'(i)) begin
        w_grant[i] = w_xfer;
        w_sel_rd   = req_rd[i*5 +: 5];
        w_sel_data = req_data[i*32 +: 32];
      end
    end
  end

  assign req_ready = w_grant;

  // -------------------------------------------------------------------------
  // Busy scoreboard next state
  // -------------------------------------------------------------------------
  logic [31:0] r_busy;
  logic [31:0] w_busy_nxt;
  logic        w_clr_en;
  logic        w_set_en;

  assign w_clr_en = w_xfer && (w_sel_rd != 5'd0);
  assign w_set_en = disp_valid && (disp_rd != 5'd0);

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_clr_en) begin
      w_busy_nxt[w_sel_rd] = 1'b0;
    end
    // Applied after the clear: a new producer for the same register
    // supersedes the one that is retiring this cycle.
    if (w_set_en) begin
      w_busy_nxt[disp_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // -------------------------------------------------------------------------
  // Write stage and scoreboard registers
  // -------------------------------------------------------------------------
  logic        r_regf_we;
  logic [4:0]  r_rd_s;
  logic [31:0] r_rd_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_regf_we <= 1'b0;
      r_rd_s    <= '0;
      r_rd_v    <= '0;
      r_busy    <= '0;
    end else begin
      // Writes to x0 are consumed but never reach the register file.
      r_regf_we <= w_clr_en;
      if (w_xfer) begin
        r_rd_s <= w_sel_rd;
        r_rd_v <= w_sel_data;
      end
      r_busy <= w_busy_nxt;
    end
  end

  assign regf_we = r_regf_we;
  assign rd_s    = r_rd_s;
  assign rd_v    = r_rd_v;
  assign busy    = r_busy;

endmodule
